llc_stall_tracker: RTL and testbench

Parametrised successor of the LLC single-entry stall/pending register bank. It holds up to NUM_STALL stalled requests in a set/tag table with set-conflict lookup and set-based wakeup. It walks all sets for reset and flush, and it runs a DMA address/beat counter for multi-beat transfers. It sits beside the LLC decoder and process stages and replaces the single req_in_stalled_set/tag pair, the rst/flush set counter and the DMA address register.

---
 rtl/llc_stall_tracker_if.sv | 64 ++++++
 rtl/llc_stall_tracker.sv | 178 +++++++++++++++++
 tb/tb_llc_stall_tracker.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/llc_stall_tracker_if.sv
// Signal bundle between the LLC decoder/process stages and llc_stall_tracker.
// The stall tracker drives the slave side; the pipeline (or bench) drives the master side.
interface llc_stall_tracker_if #(
  parameter int SET_BITS  = 8,
  parameter int TAG_BITS  = 16,
  parameter int NUM_STALL = 4,
  parameter int ADDR_BITS = 32,
  parameter int LEN_BITS  = 8
);
  localparam int IDX_BITS = (NUM_STALL > 1) ? $clog2(NUM_STALL) : 1;

  // Handshakes: a transfer happens on a rising edge where valid && ready. For alloc, ready is
  // alloc_ready; for resume, ready is resume_ack. A valid without ready is dropped, not held.
  // rel, wake, walk and dma inputs are single-cycle strobes with no ready.
  logic                 alloc_valid;
  logic [SET_BITS-1:0]  alloc_set;
  logic [TAG_BITS-1:0]  alloc_tag;
  logic                 alloc_ready;
  logic [IDX_BITS-1:0]  alloc_idx;
  logic                 rel_valid;
  logic [IDX_BITS-1:0]  rel_idx;
  logic [SET_BITS-1:0]  lookup_set;
  logic                 set_conflict;
  logic                 wake_valid;
  logic [SET_BITS-1:0]  wake_set;
  logic                 resume_valid;
  logic [IDX_BITS-1:0]  resume_idx;
  logic [SET_BITS-1:0]  resume_set;
  logic [TAG_BITS-1:0]  resume_tag;
  logic                 resume_ack;
  logic [IDX_BITS:0]    stall_count;
  logic                 walk_start;
  logic                 walk_mode;
  logic                 walk_step;
  logic                 walk_busy;
  logic                 walk_is_flush;
  logic [SET_BITS-1:0]  walk_set;
  logic                 walk_done;
  logic                 dma_load;
  logic [ADDR_BITS-1:0] dma_addr_in;
  logic [LEN_BITS-1:0]  dma_len;
  logic                 dma_step;
  logic [ADDR_BITS-1:0] dma_addr;
  logic                 dma_active;
  logic                 dma_last;

  modport slave (
    input  alloc_valid, alloc_set, alloc_tag, rel_valid, rel_idx, lookup_set,
           wake_valid, wake_set, resume_ack, walk_start, walk_mode, walk_step,
           dma_load, dma_addr_in, dma_len, dma_step,
    output alloc_ready, alloc_idx, set_conflict, resume_valid, resume_idx, resume_set,
           resume_tag, stall_count, walk_busy, walk_is_flush, walk_set, walk_done,
           dma_addr, dma_active, dma_last
  );

  modport master (
    output alloc_valid, alloc_set, alloc_tag, rel_valid, rel_idx, lookup_set,
           wake_valid, wake_set, resume_ack, walk_start, walk_mode, walk_step,
           dma_load, dma_addr_in, dma_len, dma_step,
    input  alloc_ready, alloc_idx, set_conflict, resume_valid, resume_idx, resume_set,
           resume_tag, stall_count, walk_busy, walk_is_flush, walk_set, walk_done,
           dma_addr, dma_active, dma_last
  );
endinterface

// File: rtl/llc_stall_tracker.sv
// Multi-entry LLC stall table with set-conflict lookup and set wakeup, plus the
// reset/flush set walker and the DMA line-address/beat counter.
module llc_stall_tracker #(
  parameter int SET_BITS  = 8,
  parameter int TAG_BITS  = 16,
  parameter int NUM_STALL = 4,
  parameter int ADDR_BITS = 32,
  parameter int LEN_BITS  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  llc_stall_tracker_if.slave    bus
);
  localparam int IDX_BITS = (NUM_STALL > 1) ? $clog2(NUM_STALL) : 1;
  localparam logic [SET_BITS-1:0] LAST_SET = {SET_BITS{1'b1}};

  logic [NUM_STALL-1:0] valid_q, woken_q, valid_d, woken_d;
  logic [SET_BITS-1:0]  set_q [NUM_STALL];
  logic [TAG_BITS-1:0]  tag_q [NUM_STALL];
  logic [IDX_BITS:0]    count_q, count_d;

  logic                 alloc_ready_c, resume_valid_c, conflict_c;
  logic [IDX_BITS-1:0]  alloc_idx_c, resume_idx_c;
  logic [SET_BITS-1:0]  resume_set_c;
  logic [TAG_BITS-1:0]  resume_tag_c;
  logic                 alloc_fire, ack_fire;

  // Priority pickers run high-to-low so the last hit is the lowest index.
  always_comb begin
    alloc_ready_c  = 1'b0;
    alloc_idx_c    = '0;
    resume_valid_c = 1'b0;
    resume_idx_c   = '0;
    resume_set_c   = '0;
    resume_tag_c   = '0;
    conflict_c     = 1'b0;
    for (int i = NUM_STALL - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        alloc_ready_c = 1'b1;
        alloc_idx_c   = IDX_BITS'(i);
      end
      if (woken_q[i]) begin
        resume_valid_c = 1'b1;
        resume_idx_c   = IDX_BITS'(i);
        resume_set_c   = set_q[i];
        resume_tag_c   = tag_q[i];
      end
      if (valid_q[i] && set_q[i] == bus.lookup_set) conflict_c = 1'b1;
    end
  end

  assign alloc_fire = bus.alloc_valid && alloc_ready_c;
  assign ack_fire   = bus.resume_ack && resume_valid_c;

  // Wake sees only pre-edge valid entries, so a slot being allocated now stays unwoken.
  always_comb begin
    valid_d = valid_q;
    woken_d = woken_q;
    count_d = '0;
    for (int i = 0; i < NUM_STALL; i++) begin
      if (bus.wake_valid && valid_q[i] && set_q[i] == bus.wake_set) woken_d[i] = 1'b1;
      if ((bus.rel_valid && bus.rel_idx == IDX_BITS'(i)) ||
          (ack_fire && resume_idx_c == IDX_BITS'(i))) begin
        valid_d[i] = 1'b0;
        woken_d[i] = 1'b0;
      end
      if (alloc_fire && alloc_idx_c == IDX_BITS'(i)) begin
        valid_d[i] = 1'b1;
        woken_d[i] = 1'b0;
      end
      count_d = count_d + {{IDX_BITS{1'b0}}, valid_d[i]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      woken_q <= '0;
      count_q <= '0;
      for (int i = 0; i < NUM_STALL; i++) begin
        set_q[i] <= '0;
        tag_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      woken_q <= woken_d;
      count_q <= count_d;
      for (int i = 0; i < NUM_STALL; i++) begin
        if (alloc_fire && alloc_idx_c == IDX_BITS'(i)) begin
          set_q[i] <= bus.alloc_set;
          tag_q[i] <= bus.alloc_tag;
        end
      end
    end
  end

  assign bus.alloc_ready  = alloc_ready_c;
  assign bus.alloc_idx    = alloc_idx_c;
  assign bus.set_conflict = conflict_c;
  assign bus.resume_valid = resume_valid_c;
  assign bus.resume_idx   = resume_idx_c;
  assign bus.resume_set   = resume_set_c;
  assign bus.resume_tag   = resume_tag_c;
  assign bus.stall_count  = count_q;

  typedef enum logic {WALK_IDLE = 1'b0, WALK_RUN = 1'b1} walk_state_t;

  walk_state_t         walk_state_q, walk_state_d;
  logic [SET_BITS-1:0] walk_set_q, walk_set_d;
  logic                walk_flush_q, walk_flush_d;
  logic                walk_done_q, walk_done_d;

  // Reset lands in a reset-mode walk: the cache stalls until every set is initialised.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      walk_state_q <= WALK_RUN;
      walk_set_q   <= '0;
      walk_flush_q <= 1'b0;
      walk_done_q  <= 1'b0;
    end else begin
      walk_state_q <= walk_state_d;
      walk_set_q   <= walk_set_d;
      walk_flush_q <= walk_flush_d;
      walk_done_q  <= walk_done_d;
    end
  end

  always_comb begin
    walk_state_d = walk_state_q;
    walk_set_d   = walk_set_q;
    walk_flush_d = walk_flush_q;
    walk_done_d  = 1'b0;
    case (walk_state_q)
      WALK_IDLE: begin
        if (bus.walk_start) begin
          walk_state_d = WALK_RUN;
          walk_set_d   = '0;
          walk_flush_d = bus.walk_mode;
        end
      end
      WALK_RUN: begin
        if (bus.walk_step) begin
          walk_set_d = walk_set_q + 1'b1;
          if (walk_set_q == LAST_SET) begin
            walk_state_d = WALK_IDLE;
            walk_done_d  = 1'b1;
          end
        end
      end
      default: walk_state_d = WALK_IDLE;
    endcase
  end

  assign bus.walk_busy     = (walk_state_q == WALK_RUN);
  assign bus.walk_is_flush = walk_flush_q;
  assign bus.walk_set      = walk_set_q;
  assign bus.walk_done     = walk_done_q;

  logic [ADDR_BITS-1:0] dma_addr_q;
  logic [LEN_BITS-1:0]  dma_rem_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dma_addr_q <= '0;
      dma_rem_q  <= '0;
    end else if (bus.dma_load) begin
      dma_addr_q <= bus.dma_addr_in;
      dma_rem_q  <= bus.dma_len;
    end else if (bus.dma_step && dma_rem_q != '0) begin
      dma_addr_q <= dma_addr_q + 1'b1;
      dma_rem_q  <= dma_rem_q - 1'b1;
    end
  end

  assign bus.dma_addr   = dma_addr_q;
  assign bus.dma_active = (dma_rem_q != '0);
  assign bus.dma_last   = (dma_rem_q == LEN_BITS'(1));
endmodule

// File: tb/tb_llc_stall_tracker.sv
// Bench for llc_stall_tracker: directed scenarios plus random traffic, all outputs
// compared every cycle against a behavioural model of table, walker and DMA counter.
module tb_llc_stall_tracker;
  localparam int SET_BITS  = 8;
  localparam int TAG_BITS  = 16;
  localparam int NUM_STALL = 4;
  localparam int ADDR_BITS = 32;
  localparam int LEN_BITS  = 8;
  localparam int NUM_SETS  = 1 << SET_BITS;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  llc_stall_tracker_if #(.SET_BITS(SET_BITS), .TAG_BITS(TAG_BITS), .NUM_STALL(NUM_STALL),
                         .ADDR_BITS(ADDR_BITS), .LEN_BITS(LEN_BITS)) bus ();

  llc_stall_tracker #(.SET_BITS(SET_BITS), .TAG_BITS(TAG_BITS), .NUM_STALL(NUM_STALL),
                      .ADDR_BITS(ADDR_BITS), .LEN_BITS(LEN_BITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_total = 0;
  int n_bad   = 0;

  // reference model state
  bit    m_v [NUM_STALL];
  bit    m_w [NUM_STALL];
  int    m_s [NUM_STALL];
  int    m_t [NUM_STALL];
  bit    m_busy, m_flush, m_done;
  int    m_wset;
  longint m_addr;
  int    m_rem;

  // expected combinational outputs for the current cycle
  bit e_ready, e_conf, e_rv;
  int e_aidx, e_ridx;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_STALL; i++) begin
      m_v[i] = 0; m_w[i] = 0; m_s[i] = 0; m_t[i] = 0;
    end
    m_busy = 1; m_flush = 0; m_done = 0; m_wset = 0;
    m_addr = 0; m_rem = 0;
  endtask

  task automatic clear_in();
    bus.alloc_valid = 0; bus.alloc_set = '0; bus.alloc_tag = '0;
    bus.rel_valid = 0; bus.rel_idx = '0; bus.lookup_set = '0;
    bus.wake_valid = 0; bus.wake_set = '0; bus.resume_ack = 0;
    bus.walk_start = 0; bus.walk_mode = 0; bus.walk_step = 0;
    bus.dma_load = 0; bus.dma_addr_in = '0; bus.dma_len = '0; bus.dma_step = 0;
  endtask

  task automatic check_comb();
    int nvalid;
    e_ready = 0; e_aidx = 0; e_conf = 0; e_rv = 0; e_ridx = 0;
    nvalid = 0;
    for (int i = 0; i < NUM_STALL; i++) begin
      if (m_v[i]) nvalid++;
      if (!m_v[i] && !e_ready) begin e_ready = 1; e_aidx = i; end
      if (m_w[i] && !e_rv) begin e_rv = 1; e_ridx = i; end
      if (m_v[i] && m_s[i] == int'(bus.lookup_set)) e_conf = 1;
    end
    check_eq("alloc_ready", bus.alloc_ready, e_ready);
    check_eq("alloc_idx", bus.alloc_idx, e_aidx);
    check_eq("set_conflict", bus.set_conflict, e_conf);
    check_eq("resume_valid", bus.resume_valid, e_rv);
    if (e_rv) begin
      check_eq("resume_idx", bus.resume_idx, e_ridx);
      check_eq("resume_set", bus.resume_set, m_s[e_ridx]);
      check_eq("resume_tag", bus.resume_tag, m_t[e_ridx]);
    end
  endtask

  task automatic model_step();
    // table: wake on pre-edge entries, then clears, then the new allocation
    for (int i = 0; i < NUM_STALL; i++)
      if (bus.wake_valid && m_v[i] && m_s[i] == int'(bus.wake_set)) m_w[i] = 1;
    if (bus.rel_valid) begin m_v[bus.rel_idx] = 0; m_w[bus.rel_idx] = 0; end
    if (bus.resume_ack && e_rv) begin m_v[e_ridx] = 0; m_w[e_ridx] = 0; end
    if (bus.alloc_valid && e_ready) begin
      m_v[e_aidx] = 1; m_w[e_aidx] = 0;
      m_s[e_aidx] = int'(bus.alloc_set); m_t[e_aidx] = int'(bus.alloc_tag);
    end
    // walker: a counter over NUM_SETS sets
    m_done = 0;
    if (m_busy) begin
      if (bus.walk_step) begin
        m_wset = (m_wset + 1) % NUM_SETS;
        if (m_wset == 0) begin m_busy = 0; m_done = 1; end
      end
    end else if (bus.walk_start) begin
      m_busy = 1; m_flush = bus.walk_mode; m_wset = 0;
    end
    // dma
    if (bus.dma_load) begin
      m_addr = longint'(bus.dma_addr_in); m_rem = int'(bus.dma_len);
    end else if (bus.dma_step && m_rem > 0) begin
      m_addr = (m_addr + 1) & 64'hFFFF_FFFF; m_rem--;
    end
  endtask

  task automatic check_regs();
    int cnt;
    cnt = 0;
    for (int i = 0; i < NUM_STALL; i++) if (m_v[i]) cnt++;
    check_eq("stall_count", bus.stall_count, cnt);
    check_eq("walk_busy", bus.walk_busy, m_busy);
    check_eq("walk_is_flush", bus.walk_is_flush, m_flush);
    check_eq("walk_set", bus.walk_set, m_wset);
    check_eq("walk_done", bus.walk_done, m_done);
    check_eq("dma_addr", bus.dma_addr, m_addr);
    check_eq("dma_active", bus.dma_active, m_rem != 0);
    check_eq("dma_last", bus.dma_last, m_rem == 1);
  endtask

  // inputs are driven at posedge+1; outputs checked at posedge+3 and after the next edge
  task automatic tick();
    #2;
    check_comb();
    model_step();
    @(posedge clk);
    #1;
    check_regs();
    clear_in();
  endtask

  task automatic do_alloc(input int s, input int t);
    bus.alloc_valid = 1; bus.alloc_set = SET_BITS'(s); bus.alloc_tag = TAG_BITS'(t);
    tick();
  endtask

  initial begin
    clear_in();
    model_reset();
    #2 rst = 1;
    #1;
    check_eq("rst_busy", bus.walk_busy, 1);
    check_eq("rst_count", bus.stall_count, 0);
    check_eq("rst_ready", bus.alloc_ready, 1);
    check_eq("rst_dma_active", bus.dma_active, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 0;
    check_regs();

    // reset walk over every set
    for (int k = 0; k < NUM_SETS; k++) begin
      check_eq("walk_set_seq", bus.walk_set, k);
      bus.walk_step = 1;
      tick();
    end
    check_eq("walk_done_end", bus.walk_done, 1);
    check_eq("walk_busy_end", bus.walk_busy, 0);
    tick();
    check_eq("walk_done_pulse", bus.walk_done, 0);

    // fill the table
    do_alloc(5, 'h11);
    do_alloc(9, 'h22);
    do_alloc(5, 'h33);
    check_eq("alloc_idx_3", bus.alloc_idx, 3);
    do_alloc(7, 'h44);
    check_eq("full_ready", bus.alloc_ready, 0);
    check_eq("full_count", bus.stall_count, 4);
    do_alloc(1, 'h99);
    check_eq("full_ignored", bus.stall_count, 4);
    bus.lookup_set = 5; #1;
    check_eq("conflict_5", bus.set_conflict, 1);
    bus.lookup_set = 6; #1;
    check_eq("conflict_6", bus.set_conflict, 0);
    bus.lookup_set = 0;

    // release with simultaneous alloc on a full table
    bus.rel_valid = 1; bus.rel_idx = 1;
    do_alloc(3, 'h55);
    check_eq("rel_alloc_idx", bus.alloc_idx, 1);
    check_eq("rel_count", bus.stall_count, 3);
    do_alloc(3, 'h55);
    check_eq("refill_count", bus.stall_count, 4);

    // wakeup and resume
    for (int k = 0; k < NUM_STALL; k++) begin
      bus.rel_valid = 1; bus.rel_idx = 2'(k);
      tick();
    end
    do_alloc(5, 'h11);
    do_alloc(9, 'h22);
    do_alloc(5, 'h33);
    bus.wake_valid = 1; bus.wake_set = 5;
    tick();
    check_eq("wake_idx0", bus.resume_idx, 0);
    check_eq("wake_tag0", bus.resume_tag, 'h11);
    bus.resume_ack = 1;
    tick();
    check_eq("wake_idx2", bus.resume_idx, 2);
    check_eq("wake_tag2", bus.resume_tag, 'h33);
    bus.resume_ack = 1;
    tick();
    check_eq("wake_none", bus.resume_valid, 0);
    check_eq("wake_left", bus.stall_count, 1);

    // dma wrap
    bus.dma_load = 1; bus.dma_addr_in = 32'hFFFF_FFFE; bus.dma_len = 3;
    tick();
    bus.dma_step = 1; tick();
    check_eq("dma_a1", bus.dma_addr, 32'hFFFF_FFFF);
    bus.dma_step = 1; tick();
    check_eq("dma_a2", bus.dma_addr, 0);
    check_eq("dma_last2", bus.dma_last, 1);
    bus.dma_step = 1; tick();
    check_eq("dma_a3", bus.dma_addr, 1);
    check_eq("dma_done", bus.dma_active, 0);
    bus.dma_step = 1; tick();
    check_eq("dma_a4", bus.dma_addr, 1);

    // random traffic
    for (int k = 0; k < 2000; k++) begin
      bus.alloc_valid = ($urandom_range(0, 1) == 1);
      bus.alloc_set   = SET_BITS'($urandom_range(0, 7));
      bus.alloc_tag   = TAG_BITS'($urandom);
      bus.rel_valid   = ($urandom_range(0, 4) == 0);
      bus.rel_idx     = 2'($urandom_range(0, NUM_STALL - 1));
      bus.lookup_set  = SET_BITS'($urandom_range(0, 7));
      bus.wake_valid  = ($urandom_range(0, 4) == 0);
      bus.wake_set    = SET_BITS'($urandom_range(0, 7));
      bus.resume_ack  = ($urandom_range(0, 2) == 0);
      bus.walk_start  = ($urandom_range(0, 19) == 0);
      bus.walk_mode   = $urandom_range(0, 1) == 1;
      bus.walk_step   = ($urandom_range(0, 2) == 0);
      bus.dma_load    = ($urandom_range(0, 19) == 0);
      bus.dma_addr_in = ADDR_BITS'($urandom);
      bus.dma_len     = LEN_BITS'($urandom_range(0, 5));
      bus.dma_step    = ($urandom_range(0, 1) == 1);
      tick();
    end

    // flush walk interrupted by asynchronous reset
    for (int k = 0; k < 2 * NUM_SETS && m_busy; k++) begin
      bus.walk_step = 1;
      tick();
    end
    check_eq("walk_idle", bus.walk_busy, 0);
    bus.walk_start = 1; bus.walk_mode = 1;
    tick();
    do_alloc(1, 'h77);
    for (int k = 0; k < 40; k++) begin
      bus.walk_step = 1;
      tick();
    end
    check_eq("flush_mode", bus.walk_is_flush, 1);
    check_eq("flush_set40", bus.walk_set, 40);
    #1 rst = 1;
    #1;
    model_reset();
    check_eq("arst_busy", bus.walk_busy, 1);
    check_eq("arst_flush", bus.walk_is_flush, 0);
    check_eq("arst_set", bus.walk_set, 0);
    check_eq("arst_count", bus.stall_count, 0);
    check_eq("arst_ready", bus.alloc_ready, 1);
    check_eq("arst_idx", bus.alloc_idx, 0);
    check_eq("arst_resume", bus.resume_valid, 0);
    check_eq("arst_dma", bus.dma_addr, 0);
    @(posedge clk);
    #1 rst = 0;
    check_regs();
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
